// File: rtl/join_pkg.sv
// Shared types and default parameters for the N-channel two-phase join.
package join_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIRE    = 2'd2
    } state_t;

    localparam int unsigned JOIN_N_DEF           = 2;
    localparam int unsigned JOIN_SYNC_STAGES_DEF = 2;
    localparam int unsigned JOIN_TO_CYCLES_DEF   = 1024;

endpackage

// File: rtl/sync_ff.sv
// Resettable multi-flop synchroniser for one asynchronous level signal.
module sync_ff
    import join_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = JOIN_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/join_rn_2ph.sv
// Clocked N-way two-phase join with input synchronisers, masking and error flags.
// Optional starvation timeout is built only when JOIN_TIMEOUT_EN is defined.
module join_rn_2ph
    import join_pkg::*;
#(
    parameter int unsigned N           = JOIN_N_DEF,
    parameter int unsigned SYNC_STAGES = JOIN_SYNC_STAGES_DEF,
    parameter int unsigned TO_CYCLES   = JOIN_TO_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] ack_o,
    input  logic [N-1:0] en_i,
    output logic         req_o,
    input  logic         ack_i,
    output logic [N-1:0] pending_o,
    output logic         proto_err_o,
    output logic         timeout_o
);

    if (N < 2 || SYNC_STAGES < 2 || TO_CYCLES < 1) begin : g_bad_param
        $error("join_rn_2ph: N and SYNC_STAGES must be >= 2, TO_CYCLES >= 1");
    end

    logic [N-1:0] req_s;
    logic         ack_s;

    for (genvar g = 0; g < N; g++) begin : g_req_sync
        sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
            .clk (clk),
            .rst (rst),
            .d   (req_i[g]),
            .q   (req_s[g])
        );
    end

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (ack_i),
        .q   (ack_s)
    );

    state_t       state;
    logic [N-1:0] mask;
    logic [N-1:0] pending;
    logic [N-1:0] evt;
    logic [N-1:0] arrive;
    logic [N-1:0] collected;
    logic         all_in;
    logic         done;
    logic         err_req;
    logic         err_ack;

    // Arrivals are folded in combinationally so the last one fires req_o on its own edge.
    always_comb begin
        evt       = req_s ^ ack_o;
        arrive    = mask & evt & ~pending;
        collected = pending | arrive;
        all_in    = &(collected | ~mask);
        done      = (ack_s == req_o);
        err_req   = |(pending & ~evt);
        err_ack   = (state != FIRE) && !done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            pending     <= '0;
            req_o       <= 1'b0;
            ack_o       <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (err_req || err_ack) begin
                proto_err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|(en_i & evt)) begin
                        mask  <= en_i;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    pending <= collected;
                    if (all_in) begin
                        req_o <= ~req_o;
                        state <= FIRE;
                    end
                end
                FIRE: begin
                    if (done) begin
                        ack_o   <= ack_o ^ mask;
                        pending <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pending_o = pending;

`ifdef JOIN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state != COLLECT) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_W'(TO_CYCLES)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == COLLECT && to_cnt == TO_W'(TO_CYCLES)) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign timeout_o = to_flag;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_join_rn_2ph.sv
// Scoreboard bench for join_rn_2ph: directed joins, masking, errors, timeout, reset.
module tb_join_rn_2ph;

    localparam int unsigned N  = 3;
    localparam int unsigned S  = 2;
    localparam int unsigned TO = 16;

`ifdef JOIN_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_i;
    logic [N-1:0] ack_o;
    logic [N-1:0] en_i;
    logic         req_o;
    logic         ack_i;
    logic [N-1:0] pending_o;
    logic         proto_err_o;
    logic         timeout_o;

    join_rn_2ph #(.N(N), .SYNC_STAGES(S), .TO_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .en_i        (en_i),
        .req_o       (req_o),
        .ack_i       (ack_i),
        .pending_o   (pending_o),
        .proto_err_o (proto_err_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [N-1:0] val;
        logic [31:0]  at;
    } exp_t;

    exp_t req_q[$];
    exp_t ack_q[$];

    int checks = 0;
    int errors = 0;

    logic         exp_req;
    logic [N-1:0] exp_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected req_o toggle, seen by the monitor at the negedge following edge `at`.
    task automatic push_req(input logic [31:0] at);
        exp_req = ~exp_req;
        req_q.push_back('{val: N'(exp_req), at: at});
    endtask

    task automatic do_ack(input logic [N-1:0] m);
        exp_ack = exp_ack ^ m;
        ack_q.push_back('{val: exp_ack, at: cyc + 1 + S});
        ack_i = ~ack_i;
    endtask

    task automatic do_reset();
        #2;
        rst   = 1'b1;
        req_i = '0;
        ack_i = 1'b0;
        req_q.delete();
        ack_q.delete();
        exp_req = 1'b0;
        exp_ack = '0;
        #1;
        chk("rst_req_o", req_o, 0);
        chk("rst_ack_o", ack_o, 0);
        chk("rst_pending_o", pending_o, 0);
        chk("rst_proto_err_o", proto_err_o, 0);
        chk("rst_timeout_o", timeout_o, 0);
        tick(2);
        #2 rst = 1'b0;
        tick(1);
    endtask

    // Monitor: pops the scoreboard whenever req_o or ack_o changes.
    logic         prev_req;
    logic [N-1:0] prev_ack;
    initial begin
        exp_t e;
        prev_req = 1'b0;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = req_o;
                prev_ack = ack_o;
            end else begin
                if (req_o !== prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_o_unexpected actual=%0h required=%0h (cycle %0d)",
                                 req_o, prev_req, cyc);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_o_val", 32'(req_o), 32'(e.val));
                        chk("req_o_cycle", cyc, e.at);
                    end
                    prev_req = req_o;
                end
                if (ack_o !== prev_ack) begin
                    if (ack_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ack_o_unexpected actual=%0h required=%0h (cycle %0d)",
                                 ack_o, prev_ack, cyc);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_o_val", 32'(ack_o), 32'(e.val));
                        chk("ack_o_cycle", cyc, e.at);
                        chk("pending_at_ack", 32'(pending_o), 0);
                    end
                    prev_ack = ack_o;
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        req_i   = '0;
        ack_i   = 1'b0;
        en_i    = '0;
        exp_req = 1'b0;
        exp_ack = '0;

        do_reset();

        // Full 3-way join, channels arriving 10 cycles apart.
        en_i = 3'b111;
        req_i ^= 3'b001;
        tick(10);
        chk("t1_pend_a", 32'(pending_o), 32'(3'b001));
        req_i ^= 3'b100;
        tick(10);
        chk("t1_pend_b", 32'(pending_o), 32'(3'b101));
        push_req(cyc + 1 + S);
        req_i ^= 3'b010;
        tick(10);
        chk("t1_pend_full", 32'(pending_o), 32'(3'b111));
        do_ack(3'b111);
        tick(10);
        chk("t1_pend_clear", 32'(pending_o), 0);

        // Masked join: channel 1 toggles too but is held.
        en_i = 3'b101;
        req_i ^= 3'b011;
        tick(5);
        chk("t2_pend_a", 32'(pending_o), 32'(3'b001));
        push_req(cyc + 1 + S);
        req_i ^= 3'b100;
        tick(10);
        chk("t2_pend_full", 32'(pending_o), 32'(3'b101));
        do_ack(3'b101);
        tick(10);

        // All channels disabled: held request on channel 1 stays idle.
        en_i = 3'b000;
        tick(10);
        chk("t3_idle_pend", 32'(pending_o), 0);
        chk("t3_idle_req", 32'(req_o), 32'(exp_req));
        en_i = 3'b010;
        push_req(cyc + 2);
        tick(10);
        do_ack(3'b010);
        tick(10);
        chk("t3_no_err", 32'(proto_err_o), 0);

        // Simultaneous arrivals from IDLE, then a stray ack_i toggle.
        en_i = 3'b111;
        push_req(cyc + 1 + S + 1);
        req_i ^= 3'b111;
        tick(10);
        do_ack(3'b111);
        tick(10);
        chk("t4_no_err", 32'(proto_err_o), 0);
        ack_i = ~ack_i;
        tick(S + 3);
        chk("t4_ack_err", 32'(proto_err_o), 1);
        tick(5);
        chk("t4_ack_err_sticky", 32'(proto_err_o), 1);
        do_reset();

        // Starvation, double toggle, then reset while in FIRE.
        req_i ^= 3'b001;
        tick(S + 4);
        chk("t5_pend", 32'(pending_o), 32'(3'b001));
        chk("t5_timeout_early", 32'(timeout_o), 0);
        tick(20);
        chk("t5_timeout", 32'(timeout_o), 32'(TO_EXP));
        chk("t5_no_err", 32'(proto_err_o), 0);
        req_i ^= 3'b001;
        tick(S + 2);
        chk("t5_req_err", 32'(proto_err_o), 1);
        tick(8);
        chk("t5_req_err_sticky", 32'(proto_err_o), 1);
        push_req(cyc + 1 + S);
        req_i ^= 3'b110;
        tick(S + 3);
        chk("t5_fire_req", 32'(req_o), 1);
        chk("t5_fire_pend", 32'(pending_o), 32'(3'b111));
        do_reset();

        // Fresh join after reset.
        push_req(cyc + 1 + S + 1);
        req_i ^= 3'b111;
        tick(10);
        do_ack(3'b111);
        tick(10);
        chk("t6_pend_clear", 32'(pending_o), 0);
        chk("t6_no_err", 32'(proto_err_o), 0);
        chk("t6_no_timeout", 32'(timeout_o), 0);
        chk("final_ack_o", 32'(ack_o), 32'(exp_ack));
        chk("req_q_drained", req_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/join_rn_2ph.md
# join_rn_2ph

Clocked, parametrised N-channel two-phase (transition-signalling) join. It raises one output request event once every enabled input channel has issued a request event. When the output acknowledge event returns, it acknowledges all participating inputs together. It is the synchronous, N-way successor of the two-input request-AND join. It sits at the boundary between self-timed producers and the clocked fabric, and includes input synchronisers, per-channel masking, protocol-error detection and an optional starvation timeout.

## Interface
- N, 2, number of input channels (≥2)
- SYNC_STAGES, 2, flip-flop depth of each req_i/ack_i synchroniser (≥2)
- TO_CYCLES, 1024, timeout threshold in clk cycles (used only with JOIN_TIMEOUT_EN)
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_i  input  N  per-channel 2-phase request, asynchronous to clk
- ack_o  output  N  per-channel 2-phase acknowledge, registered
- en_i  input  N  channel enable mask, synchronous to clk
- req_o  output  1  joined 2-phase request, registered
- ack_i  input  1  2-phase acknowledge for req_o, asynchronous to clk
- pending_o  output  N  channel i has an unacknowledged request captured
- proto_err_o  output  1  sticky protocol-violation flag
- timeout_o  output  1  sticky starvation flag

## Operation
- Reset (rst=1, asynchronous): ack_o=0, req_o=0, pending_o=0, proto_err_o=0, timeout_o=0, all synchroniser flops 0, mask register 0, state IDLE.
- Event detection: channel i has a new request when sync(req_i[i]) != ack_o[i]. The output is complete when sync(ack_i) == req_o.
- State IDLE: no pending. Go to COLLECT when any enabled channel has a new request. On that edge, latch en_i into the mask register. en_i changes outside IDLE are ignored.
- State COLLECT: set pending[i] for each masked channel as its event arrives. When all masked channels are pending, toggle req_o and go to FIRE.
- State FIRE: wait for output completion. On completion, toggle ack_o[i] for every masked channel, clear pending, and return to IDLE.
- Unmasked channels are never acknowledged or counted. Their req_i toggles are held until a later join that has them enabled.
- en_i all zero: the block stays in IDLE indefinitely. This is not an error.
- Protocol error: proto_err_o sets if a pending channel's synced request toggles back to equal ack_o[i], meaning a second transition before acknowledge. It also sets if sync(ack_i) toggles while in IDLE or COLLECT. The block continues operating and the flag clears only on rst.
- Simultaneous arrivals: several channels becoming pending on the same edge is legal. If the last channel arrives on the same edge that COLLECT is entered, req_o toggles on the next edge.

## Timing
- Synchroniser latency is SYNC_STAGES edges from the first sampling edge.
- req_o toggles SYNC_STAGES+1 edges after the edge that first samples the last required req_i transition. This is SYNC_STAGES+2 edges when that transition also causes IDLE→COLLECT.
- ack_o toggles SYNC_STAGES+1 edges after the edge first sampling the ack_i transition.
- Minimum round trip with an instantly responding environment is 2·(SYNC_STAGES+1)+1 cycles.
- All outputs are glitch-free flop outputs, with no combinational path from input to output.

## Configuration
- JOIN_TIMEOUT_EN defined:
  - A $clog2(TO_CYCLES+1)-bit counter runs while in COLLECT and resets on leaving COLLECT.
  - At count == TO_CYCLES, timeout_o sets sticky and the counter saturates.
  - The join is not aborted.
- JOIN_TIMEOUT_EN undefined: no counter logic is built and timeout_o is tied 0.

## Structure
- Package join_pkg holds:
  - the state enum (IDLE, COLLECT, FIRE)
  - the default parameter constants
- Sub-module sync_ff: SYNC_STAGES-deep resettable synchroniser. It is instantiated N times for req_i and once for ack_i.
- Top level holds the FSM, pending/mask registers, error logic and the optional timeout counter.

## Test plan
- N=3, en_i=3'b111, toggle req_i[0], req_i[2], then req_i[1] 10 cycles apart → req_o rises exactly SYNC_STAGES+1 edges after req_i[1] is sampled. After the ack_i toggle, ack_o=3'b111 SYNC_STAGES+1 edges later and pending_o=0.
- en_i=3'b101, toggle req_i[0] and req_i[2] → req_o toggles, and after ack_i, ack_o=3'b101 with ack_o[1] unchanged.
- Toggle req_i[0] twice without acknowledge → proto_err_o=1 and stays 1 until rst.
- With JOIN_TIMEOUT_EN and TO_CYCLES=16, toggle only req_i[0] → timeout_o=1 after 16 cycles in COLLECT. Without the macro → timeout_o stays 0.
- Assert rst while in FIRE → req_o, ack_o, pending_o and the flags all go to 0 immediately. After release, the block accepts a fresh join from IDLE.
- Toggle all req_i on the same edge → a single req_o toggle, and a second ack_i toggle in IDLE sets proto_err_o.
